// File: rtl/seq_ctrl_unit_pkg.sv
// Shared encodings for the sequencing/control unit: opcodes, ALU ops, privilege
// levels, exception codes and the packed control word layout.
package seq_ctrl_unit_pkg;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;
   localparam logic [3:0] ALU_LUI  = 4'd10;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_S = 2'd1;
   localparam logic [1:0] PRIV_M = 2'd3;

   localparam logic [3:0] EXC_ILLEGAL = 4'd2;
   localparam logic [3:0] EXC_BREAK   = 4'd3;
   localparam logic [3:0] EXC_ECALL_U = 4'd8;
   localparam logic [3:0] EXC_ECALL_S = 4'd9;
   localparam logic [3:0] EXC_ECALL_M = 4'd11;

   localparam logic [2:0] SZ_NONE   = 3'd0;
   localparam logic [2:0] SZ_BYTE   = 3'd1;
   localparam logic [2:0] SZ_HALF   = 3'd2;
   localparam logic [2:0] SZ_WORD   = 3'd3;
   localparam logic [2:0] SZ_DOUBLE = 3'd4;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MD_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       wr_reg;
      logic       mem_to_reg;
      logic       mem_wr;
      logic [2:0] mem_size;
      logic       load_uns;
      logic       branch;
      logic [2:0] cmp;
      logic       jump;
      logic       jalr;
      logic       pc_to_reg;
      logic       pc_imm;
      logic       csr_we;
      logic [1:0] csr_op;
      logic       csr_src;
   } ctrl_t;

   localparam int unsigned CTRL_W = $bits(ctrl_t);

   // funct3 (+ alternate bit for SUB/SRA) to ALU operation
   function automatic logic [3:0] alu_from_f3(logic [2:0] f3, logic alt);
      logic [3:0] op;
      case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // mret target mode; unsupported levels fall back to U
   function automatic logic [1:0] mret_mode(logic [1:0] mpp, logic has_s);
      logic [1:0] m;
      case (mpp)
         PRIV_M:  m = PRIV_M;
         PRIV_S:  m = has_s ? PRIV_S : PRIV_U;
         default: m = PRIV_U;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// Pure combinational instruction decode: control word, M-op detect,
// synchronous exception and xRET classification for the current mode.
module seq_ctrl_decode
   import seq_ctrl_unit_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned HAS_M = 1,
   parameter int unsigned HAS_S = 1
) (
   input  logic [31:0] instr,
   input  logic [1:0]  mode,
   output ctrl_t       ctrl_c,
   output logic        md_c,
   output logic        excep_c,
   output logic [3:0]  excep_code_c,
   output logic        ret_c,
   output logic [1:0]  ret_from_c
);

   localparam bit IS64 = (XLEN == 64);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [11:0] funct12;
   logic [4:0]  rs1;
   logic        rd_nz;
   logic        illegal;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign funct12 = instr[31:20];
   assign rs1     = instr[19:15];
   assign rd_nz   = (instr[11:7] != 5'd0);

   always_comb begin
      ctrl_c       = '0;
      md_c         = 1'b0;
      illegal      = 1'b0;
      excep_c      = 1'b0;
      excep_code_c = '0;
      ret_c        = 1'b0;
      ret_from_c   = '0;

      case (opcode)
         OPC_OP: begin
            ctrl_c.wr_reg = rd_nz;
            if (funct7 == 7'b0000001) begin
               if (HAS_M != 0) md_c = 1'b1;
               else            illegal = 1'b1;
            end else if (funct7 == 7'b0000000 ||
                         (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
               ctrl_c.alu_op = alu_from_f3(funct3, funct7[5]);
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            ctrl_c.alu_src = 1'b1;
            ctrl_c.wr_reg  = rd_nz;
            ctrl_c.alu_op  = alu_from_f3(funct3, funct3 == 3'd5 && instr[30]);
            // shamt[5] only exists on a 64-bit datapath
            if (funct3 == 3'd1 && (instr[31:26] != 6'b000000 || (!IS64 && instr[25])))
               illegal = 1'b1;
            if (funct3 == 3'd5 && ((instr[31:26] != 6'b000000 && instr[31:26] != 6'b010000) ||
                                   (!IS64 && instr[25])))
               illegal = 1'b1;
         end
         OPC_OP_IMM_32: begin
            ctrl_c.alu_src = 1'b1;
            ctrl_c.wr_reg  = rd_nz;
            if (!IS64) illegal = 1'b1;
            else begin
               case (funct3)
                  3'd0: ctrl_c.alu_op = ALU_ADD;
                  3'd1: if (funct7 == 7'b0000000) ctrl_c.alu_op = ALU_SLL; else illegal = 1'b1;
                  3'd5: if (funct7 == 7'b0000000 || funct7 == 7'b0100000)
                           ctrl_c.alu_op = alu_from_f3(funct3, funct7[5]);
                        else illegal = 1'b1;
                  default: illegal = 1'b1;
               endcase
            end
         end
         OPC_OP_32: begin
            ctrl_c.wr_reg = rd_nz;
            if (!IS64) illegal = 1'b1;
            else if (funct7 == 7'b0000001) begin
               if (HAS_M != 0 && funct3 != 3'd1 && funct3 != 3'd2 && funct3 != 3'd3) md_c = 1'b1;
               else illegal = 1'b1;
            end else if ((funct7 == 7'b0000000 && (funct3 == 3'd0 || funct3 == 3'd1 || funct3 == 3'd5)) ||
                         (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))) begin
               ctrl_c.alu_op = alu_from_f3(funct3, funct7[5]);
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_LOAD: begin
            ctrl_c.alu_src    = 1'b1;
            ctrl_c.wr_reg     = rd_nz;
            ctrl_c.mem_to_reg = 1'b1;
            case (funct3)
               3'd0: ctrl_c.mem_size = SZ_BYTE;
               3'd1: ctrl_c.mem_size = SZ_HALF;
               3'd2: ctrl_c.mem_size = SZ_WORD;
               3'd3: if (IS64) ctrl_c.mem_size = SZ_DOUBLE; else illegal = 1'b1;
               3'd4: begin ctrl_c.mem_size = SZ_BYTE; ctrl_c.load_uns = 1'b1; end
               3'd5: begin ctrl_c.mem_size = SZ_HALF; ctrl_c.load_uns = 1'b1; end
               3'd6: if (IS64) begin ctrl_c.mem_size = SZ_WORD; ctrl_c.load_uns = 1'b1; end
                     else illegal = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         OPC_STORE: begin
            ctrl_c.alu_src = 1'b1;
            ctrl_c.mem_wr  = 1'b1;
            case (funct3)
               3'd0: ctrl_c.mem_size = SZ_BYTE;
               3'd1: ctrl_c.mem_size = SZ_HALF;
               3'd2: ctrl_c.mem_size = SZ_WORD;
               3'd3: if (IS64) ctrl_c.mem_size = SZ_DOUBLE; else illegal = 1'b1;
               default: illegal = 1'b1;
            endcase
         end
         OPC_BRANCH: begin
            ctrl_c.branch = 1'b1;
            ctrl_c.cmp    = funct3;
            ctrl_c.alu_op = ALU_SUB;
            if (funct3 == 3'd2 || funct3 == 3'd3) illegal = 1'b1;
         end
         OPC_JALR: begin
            ctrl_c.jump      = 1'b1;
            ctrl_c.jalr      = 1'b1;
            ctrl_c.alu_src   = 1'b1;
            ctrl_c.pc_to_reg = 1'b1;
            ctrl_c.wr_reg    = rd_nz;
            if (funct3 != 3'd0) illegal = 1'b1;
         end
         OPC_JAL: begin
            ctrl_c.jump      = 1'b1;
            ctrl_c.pc_to_reg = 1'b1;
            ctrl_c.wr_reg    = rd_nz;
         end
         OPC_LUI: begin
            ctrl_c.alu_op  = ALU_LUI;
            ctrl_c.alu_src = 1'b1;
            ctrl_c.wr_reg  = rd_nz;
         end
         OPC_AUIPC: begin
            ctrl_c.pc_imm  = 1'b1;
            ctrl_c.alu_src = 1'b1;
            ctrl_c.wr_reg  = rd_nz;
         end
         OPC_SYSTEM: begin
            if (funct3 == 3'd0) begin
               case (funct12)
                  12'h000: begin
                     excep_c = 1'b1;
                     case (mode)
                        PRIV_U:  excep_code_c = EXC_ECALL_U;
                        PRIV_S:  excep_code_c = EXC_ECALL_S;
                        default: excep_code_c = EXC_ECALL_M;
                     endcase
                  end
                  12'h001: begin
                     excep_c      = 1'b1;
                     excep_code_c = EXC_BREAK;
                  end
                  12'h302: if (mode == PRIV_M) begin
                              ret_c      = 1'b1;
                              ret_from_c = PRIV_M;
                           end else illegal = 1'b1;
                  12'h102: if (HAS_S != 0 && mode != PRIV_U) begin
                              ret_c      = 1'b1;
                              ret_from_c = PRIV_S;
                           end else illegal = 1'b1;
                  default: illegal = 1'b1;
               endcase
            end else if (funct3 == 3'd4) begin
               illegal = 1'b1;
            end else begin
               // csrrs/csrrc with a zero source never write the CSR
               ctrl_c.csr_we  = (funct3[1:0] == 2'b01) || (rs1 != 5'd0);
               ctrl_c.csr_op  = funct3[1:0];
               ctrl_c.csr_src = funct3[2];
               ctrl_c.wr_reg  = rd_nz;
            end
         end
         default: illegal = 1'b1;
      endcase

      if (illegal) begin
         excep_c      = 1'b1;
         excep_code_c = EXC_ILLEGAL;
      end
      if (excep_c) begin
         ctrl_c     = '0;
         md_c       = 1'b0;
         ret_c      = 1'b0;
         ret_from_c = '0;
      end
   end

endmodule

// File: rtl/seq_ctrl_unit.sv
// Instruction sequencing/control unit: accepts instructions, issues decoded
// control words, sequences mul/div handshakes, traps, xRETs and pipeline flush.
module seq_ctrl_unit
   import seq_ctrl_unit_pkg::*;
#(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned HAS_M        = 1,
   parameter int unsigned HAS_S        = 1,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned MD_TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   input  logic [31:0]       instr,
   output logic              instr_ready,
   output logic              ctrl_valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic              md_req,
   output logic [2:0]        md_op,
   input  logic              md_ack,
   output logic              md_kill,
   input  logic [1:0]        mpp_in,
   input  logic              spp_in,
   output logic              excep_valid,
   output logic [3:0]        excep_code,
   output logic              ret_valid,
   output logic [1:0]        ret_from,
   output logic [1:0]        mode
);

   localparam int unsigned WAIT_W  = $clog2(MD_TIMEOUT + 1);
   localparam int unsigned FLUSH_W = $clog2(FLUSH_CYCLES + 2);

   state_e             state, state_nxt;
   logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
   logic [FLUSH_W-1:0] flush_cnt, flush_cnt_nxt;
   ctrl_t              md_ctrl, md_ctrl_nxt;
   ctrl_t              ctrl_nxt;
   logic [1:0]         mode_nxt, ret_from_nxt;
   logic [3:0]         excep_code_nxt;
   logic [2:0]         md_op_nxt;
   logic               instr_ready_nxt, ctrl_valid_nxt, md_req_nxt, md_kill_nxt;
   logic               excep_valid_nxt, ret_valid_nxt, trap;

   ctrl_t      dec_ctrl;
   logic       dec_md, dec_excep, dec_ret;
   logic [3:0] dec_code;
   logic [1:0] dec_ret_from;

   seq_ctrl_decode #(
      .XLEN  (XLEN),
      .HAS_M (HAS_M),
      .HAS_S (HAS_S)
   ) u_decode (
      .instr        (instr),
      .mode         (mode),
      .ctrl_c       (dec_ctrl),
      .md_c         (dec_md),
      .excep_c      (dec_excep),
      .excep_code_c (dec_code),
      .ret_c        (dec_ret),
      .ret_from_c   (dec_ret_from)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_nxt       = state;
      wait_cnt_nxt    = wait_cnt;
      flush_cnt_nxt   = flush_cnt;
      md_ctrl_nxt     = md_ctrl;
      mode_nxt        = mode;
      md_op_nxt       = md_op;
      ctrl_nxt        = '0;
      ctrl_valid_nxt  = 1'b0;
      md_req_nxt      = 1'b0;
      md_kill_nxt     = 1'b0;
      excep_valid_nxt = 1'b0;
      excep_code_nxt  = '0;
      ret_valid_nxt   = 1'b0;
      ret_from_nxt    = '0;
      trap            = 1'b0;

      case (state)
         ST_RUN: begin
            if (instr_valid) begin
               if (dec_excep) begin
                  excep_valid_nxt = 1'b1;
                  excep_code_nxt  = dec_code;
                  trap            = 1'b1;
               end else if (dec_ret) begin
                  ret_valid_nxt = 1'b1;
                  ret_from_nxt  = dec_ret_from;
                  mode_nxt      = (dec_ret_from == PRIV_M) ? mret_mode(mpp_in, HAS_S != 0)
                                                           : (spp_in ? PRIV_S : PRIV_U);
               end else if (dec_md) begin
                  md_req_nxt   = 1'b1;
                  md_op_nxt    = instr[14:12];
                  md_ctrl_nxt  = dec_ctrl;
                  wait_cnt_nxt = '0;
                  state_nxt    = ST_MD_WAIT;
               end else begin
                  ctrl_valid_nxt = 1'b1;
                  ctrl_nxt       = dec_ctrl;
               end
            end
         end
         ST_MD_WAIT: begin
            // an ack arriving in the expiry cycle still completes normally
            if (md_ack) begin
               ctrl_valid_nxt = 1'b1;
               ctrl_nxt       = md_ctrl;
               wait_cnt_nxt   = '0;
               state_nxt      = ST_RUN;
            end else if (wait_cnt == WAIT_W'(MD_TIMEOUT - 1)) begin
               md_kill_nxt     = 1'b1;
               excep_valid_nxt = 1'b1;
               excep_code_nxt  = EXC_ILLEGAL;
               wait_cnt_nxt    = '0;
               trap            = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + WAIT_W'(1);
            end
         end
         ST_FLUSH: begin
            if (flush_cnt <= FLUSH_W'(1)) begin
               flush_cnt_nxt = '0;
               state_nxt     = ST_RUN;
            end else begin
               flush_cnt_nxt = flush_cnt - FLUSH_W'(1);
            end
         end
         default: state_nxt = ST_RUN;
      endcase

      if (trap) begin
         mode_nxt = PRIV_M;
         ctrl_nxt = '0;
      end
      if (trap || ret_valid_nxt) begin
         state_nxt     = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
         flush_cnt_nxt = FLUSH_W'(FLUSH_CYCLES);
      end

      instr_ready_nxt = (state_nxt == ST_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         flush_cnt   <= '0;
         md_ctrl     <= '0;
         mode        <= PRIV_M;
         instr_ready <= 1'b1;
         ctrl_valid  <= 1'b0;
         ctrl        <= '0;
         md_req      <= 1'b0;
         md_op       <= '0;
         md_kill     <= 1'b0;
         excep_valid <= 1'b0;
         excep_code  <= '0;
         ret_valid   <= 1'b0;
         ret_from    <= '0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         flush_cnt   <= flush_cnt_nxt;
         md_ctrl     <= md_ctrl_nxt;
         mode        <= mode_nxt;
         instr_ready <= instr_ready_nxt;
         ctrl_valid  <= ctrl_valid_nxt;
         ctrl        <= ctrl_nxt;
         md_req      <= md_req_nxt;
         md_op       <= md_op_nxt;
         md_kill     <= md_kill_nxt;
         excep_valid <= excep_valid_nxt;
         excep_code  <= excep_code_nxt;
         ret_valid   <= ret_valid_nxt;
         ret_from    <= ret_from_nxt;
      end
   end

endmodule

// File: tb/tb_seq_ctrl_unit.sv
// Directed bench for seq_ctrl_unit: vector table plus hand-written sequences
// for mul/div wait, timeout, flush length, reset and RV64-only decode.
module tb_seq_ctrl_unit;
   import seq_ctrl_unit_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              instr_valid;
   logic [31:0]       instr;
   logic              md_ack;
   logic [1:0]        mpp_in;
   logic              spp_in;

   logic              instr_ready, ctrl_valid, md_req, md_kill, excep_valid, ret_valid;
   logic [CTRL_W-1:0] ctrl;
   logic [2:0]        md_op;
   logic [3:0]        excep_code;
   logic [1:0]        ret_from, mode;

   logic              instr_ready64, ctrl_valid64, md_req64, md_kill64, excep_valid64, ret_valid64;
   logic [CTRL_W-1:0] ctrl64;
   logic [2:0]        md_op64;
   logic [3:0]        excep_code64;
   logic [1:0]        ret_from64, mode64;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_ctrl_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready), .ctrl_valid(ctrl_valid), .ctrl(ctrl),
      .md_req(md_req), .md_op(md_op), .md_ack(md_ack), .md_kill(md_kill),
      .mpp_in(mpp_in), .spp_in(spp_in), .excep_valid(excep_valid),
      .excep_code(excep_code), .ret_valid(ret_valid), .ret_from(ret_from), .mode(mode)
   );

   seq_ctrl_unit #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
      .instr_ready(instr_ready64), .ctrl_valid(ctrl_valid64), .ctrl(ctrl64),
      .md_req(md_req64), .md_op(md_op64), .md_ack(md_ack), .md_kill(md_kill64),
      .mpp_in(mpp_in), .spp_in(spp_in), .excep_valid(excep_valid64),
      .excep_code(excep_code64), .ret_valid(ret_valid64), .ret_from(ret_from64), .mode(mode64)
   );

   typedef struct {
      string       name;
      logic [31:0] ins;
      logic [1:0]  mpp;
      logic        spp;
      logic        cv;
      logic        exc;
      logic [3:0]  code;
      logic        ret;
      logic [1:0]  rf;
      logic [1:0]  md;
      logic [3:0]  alu;
      logic        wr;
      logic [2:0]  sz;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs[NV];

   function automatic vec_t mk(string nm, logic [31:0] ins, logic [1:0] mpp, logic spp,
                               logic cv, logic exc, logic [3:0] code, logic ret, logic [1:0] rf,
                               logic [1:0] md, logic [3:0] alu, logic wr, logic [2:0] sz);
      vec_t v;
      v.name = nm; v.ins = ins; v.mpp = mpp; v.spp = spp; v.cv = cv; v.exc = exc;
      v.code = code; v.ret = ret; v.rf = rf; v.md = md; v.alu = alu; v.wr = wr; v.sz = sz;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_ready();
      for (int k = 0; k < 50; k++) begin
         if (instr_ready) break;
         @(negedge clk);
      end
      check("wait_ready", 32'(instr_ready), 32'd1);
   endtask

   // drive one instruction at a negedge; returns at the first sample after acceptance
   task automatic issue(input logic [31:0] ins, input logic [1:0] mpp, input logic spp);
      wait_ready();
      @(negedge clk);
      instr = ins; mpp_in = mpp; spp_in = spp; instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      ctrl_t c;
      int    kill_at;

      //        name       instr          mpp   spp   cv    exc   code   ret   rf    mode  alu       wr    size
      vecs[0]  = mk("add",    32'h00B50533, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b1, SZ_NONE);
      vecs[1]  = mk("sub",    32'h40B50533, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_SUB,  1'b1, SZ_NONE);
      vecs[2]  = mk("addi",   32'h00550513, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b1, SZ_NONE);
      vecs[3]  = mk("lw",     32'h0005A503, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b1, SZ_WORD);
      vecs[4]  = mk("sb",     32'h00B50023, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_BYTE);
      vecs[5]  = mk("ld32",   32'h0005B503, 2'd0, 1'b0, 1'b0, 1'b1, 4'd2,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[6]  = mk("ebreak", 32'h00100073, 2'd0, 1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[7]  = mk("mret_u", 32'h30200073, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 2'd3, 2'd0, ALU_ADD,  1'b0, SZ_NONE);
      vecs[8]  = mk("ecallU", 32'h00000073, 2'd0, 1'b0, 1'b0, 1'b1, 4'd8,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[9]  = mk("mret_s", 32'h30200073, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 2'd3, 2'd1, ALU_ADD,  1'b0, SZ_NONE);
      vecs[10] = mk("ecallS", 32'h00000073, 2'd0, 1'b0, 1'b0, 1'b1, 4'd9,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[11] = mk("mret_2", 32'h30200073, 2'd2, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 2'd3, 2'd0, ALU_ADD,  1'b0, SZ_NONE);
      vecs[12] = mk("mretU",  32'h30200073, 2'd0, 1'b0, 1'b0, 1'b1, 4'd2,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[13] = mk("mret_s2",32'h30200073, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 2'd3, 2'd1, ALU_ADD,  1'b0, SZ_NONE);
      vecs[14] = mk("sret",   32'h10200073, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 2'd1, 2'd0, ALU_ADD,  1'b0, SZ_NONE);
      vecs[15] = mk("sretU",  32'h10200073, 2'd0, 1'b1, 1'b0, 1'b1, 4'd2,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[16] = mk("uret",   32'h00200073, 2'd0, 1'b0, 1'b0, 1'b1, 4'd2,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[17] = mk("ecallM", 32'h00000073, 2'd0, 1'b0, 1'b0, 1'b1, 4'd11, 1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[18] = mk("badopc", 32'h0000007F, 2'd0, 1'b0, 1'b0, 1'b1, 4'd2,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b0, SZ_NONE);
      vecs[19] = mk("beq",    32'h00B50463, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_SUB,  1'b0, SZ_NONE);
      vecs[20] = mk("lui",    32'h12345537, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_LUI,  1'b1, SZ_NONE);
      vecs[21] = mk("csrrw",  32'h34051573, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_ADD,  1'b1, SZ_NONE);
      vecs[22] = mk("xori",   32'hFFF54513, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_XOR,  1'b1, SZ_NONE);
      vecs[23] = mk("srai",   32'h40355513, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 2'd0, 2'd3, ALU_SRA,  1'b1, SZ_NONE);

      rst = 1'b1; instr_valid = 1'b0; instr = '0; md_ack = 1'b0; mpp_in = '0; spp_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mode",        32'(mode),        32'd3);
      check("rst_instr_ready", 32'(instr_ready), 32'd1);
      check("rst_ctrl_valid",  32'(ctrl_valid),  32'd0);
      check("rst_excep_valid", 32'(excep_valid), 32'd0);
      check("rst_md_kill",     32'(md_kill),     32'd0);
      check("rst_ctrl",        32'(ctrl),        32'd0);

      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].ins, vecs[i].mpp, vecs[i].spp);
         c = ctrl_t'(ctrl);
         check({vecs[i].name, ".ctrl_valid"},  32'(ctrl_valid),  32'(vecs[i].cv));
         check({vecs[i].name, ".excep_valid"}, 32'(excep_valid), 32'(vecs[i].exc));
         if (vecs[i].exc) check({vecs[i].name, ".excep_code"}, 32'(excep_code), 32'(vecs[i].code));
         check({vecs[i].name, ".ret_valid"},   32'(ret_valid),   32'(vecs[i].ret));
         if (vecs[i].ret) check({vecs[i].name, ".ret_from"}, 32'(ret_from), 32'(vecs[i].rf));
         check({vecs[i].name, ".mode"},        32'(mode),        32'(vecs[i].md));
         if (vecs[i].cv) begin
            check({vecs[i].name, ".alu_op"},   32'(c.alu_op),   32'(vecs[i].alu));
            check({vecs[i].name, ".wr_reg"},   32'(c.wr_reg),   32'(vecs[i].wr));
            check({vecs[i].name, ".mem_size"}, 32'(c.mem_size), 32'(vecs[i].sz));
         end else begin
            check({vecs[i].name, ".ctrl_nop"}, 32'(ctrl), 32'd0);
         end
         @(negedge clk);
         check({vecs[i].name, ".pulse_end"}, 32'({ctrl_valid, excep_valid, ret_valid}), 32'd0);
      end

      // trap flush: instr_ready low for exactly two cycles
      issue(32'h00000073, 2'd0, 1'b0);
      check("flush.excep_code", 32'(excep_code), 32'd11);
      check("flush.ready0", 32'(instr_ready), 32'd0);
      @(negedge clk);
      check("flush.ready1", 32'(instr_ready), 32'd0);
      @(negedge clk);
      check("flush.ready2", 32'(instr_ready), 32'd1);

      // divu with ack after five wait cycles
      issue(32'h02B55533, 2'd0, 1'b0);
      check("md.req",   32'(md_req), 32'd1);
      check("md.op",    32'(md_op),  32'd5);
      check("md.ready0",32'(instr_ready), 32'd0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("md.ready%0d", k), 32'(instr_ready), 32'd0);
         check($sformatf("md.req_off%0d", k), 32'(md_req), 32'd0);
      end
      md_ack = 1'b1;
      @(negedge clk);
      md_ack = 1'b0;
      c = ctrl_t'(ctrl);
      check("md.ctrl_valid", 32'(ctrl_valid), 32'd1);
      check("md.wr_reg",     32'(c.wr_reg),   32'd1);
      check("md.ready_back", 32'(instr_ready), 32'd1);
      @(negedge clk);
      check("md.cv_pulse",   32'(ctrl_valid), 32'd0);

      // mul with no ack: kill on the 64th wait cycle
      issue(32'h02B50533, 2'd0, 1'b0);
      kill_at = -1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (md_kill) begin
            kill_at = k;
            break;
         end
      end
      check("to.kill_cycle", 32'(kill_at), 32'd64);
      check("to.excep_valid", 32'(excep_valid), 32'd1);
      check("to.excep_code",  32'(excep_code),  32'd2);
      check("to.mode",        32'(mode),        32'd3);
      check("to.ctrl_valid",  32'(ctrl_valid),  32'd0);
      @(negedge clk);
      check("to.kill_pulse",  32'(md_kill),     32'd0);

      // ack in the expiry cycle wins over timeout
      issue(32'h02B50533, 2'd0, 1'b0);
      repeat (63) @(negedge clk);
      md_ack = 1'b1;
      @(negedge clk);
      md_ack = 1'b0;
      check("exp.ctrl_valid",  32'(ctrl_valid),  32'd1);
      check("exp.md_kill",     32'(md_kill),     32'd0);
      check("exp.excep_valid", 32'(excep_valid), 32'd0);

      // reset while waiting on mul/div
      issue(32'h02B50533, 2'd0, 1'b0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstw.md_kill",     32'(md_kill),     32'd0);
      check("rstw.instr_ready", 32'(instr_ready), 32'd1);
      check("rstw.mode",        32'(mode),        32'd3);
      @(negedge clk);
      rst = 1'b0;
      repeat (70) @(negedge clk);
      check("rstw.no_late_kill", 32'(md_kill), 32'd0);
      check("rstw.idle_excep",   32'(excep_valid), 32'd0);

      // addiw: illegal on 32-bit, legal on 64-bit
      issue(32'h0000051B, 2'd0, 1'b0);
      check("addiw32.excep_valid", 32'(excep_valid), 32'd1);
      check("addiw32.excep_code",  32'(excep_code),  32'd2);
      c = ctrl_t'(ctrl64);
      check("addiw64.ctrl_valid",  32'(ctrl_valid64),  32'd1);
      check("addiw64.excep_valid", 32'(excep_valid64), 32'd0);
      check("addiw64.wr_reg",      32'(c.wr_reg),      32'd1);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
